// File: rtl/array_pkg.sv
// Shared sizing constants and controller state encoding for the 4x4 array sequencer.
package array_pkg;
  localparam int DIM         = 4;
  localparam int DATA_WIDTH  = 8;
  localparam int ACC_WIDTH   = 16;
  localparam int FEED_CYCLES = 3 * DIM - 2;
  localparam int STEP_W      = $clog2(FEED_CYCLES);
  localparam int ADDR_W      = $clog2(DIM * DIM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_CAPTURE,
    S_DONE
  } state_t;
endpackage

// File: rtl/array_ctrl_operand_skew.sv
// A/B operand buffers plus the diagonal skew mux that feeds the array edges.
module operand_skew #(
  parameter int DIM        = array_pkg::DIM,
  parameter int DATA_WIDTH = array_pkg::DATA_WIDTH,
  parameter int STEP_W     = array_pkg::STEP_W,
  parameter int ADDR_W     = array_pkg::ADDR_W
) (
  input  logic                      clk,
  input  logic                      i_rst,
  input  logic                      i_wr_en,
  input  logic                      i_wr_sel,
  input  logic [ADDR_W-1:0]         i_wr_addr,
  input  logic [DATA_WIDTH-1:0]     i_wr_data,
  input  logic [STEP_W-1:0]         i_step,
  input  logic                      i_feed_valid,
  output logic [DATA_WIDTH*DIM-1:0] o_a_row,
  output logic [DATA_WIDTH*DIM-1:0] o_b_col
);
  import array_pkg::*;

  logic [DATA_WIDTH-1:0] r_a [DIM*DIM];
  logic [DATA_WIDTH-1:0] r_b [DIM*DIM];

  always_ff @(posedge clk) begin
    if (i_rst) begin
      for (int n = 0; n < DIM*DIM; n++) begin
        r_a[n] <= '0;
        r_b[n] <= '0;
      end
    end else if (i_wr_en) begin
      if (i_wr_sel) r_b[i_wr_addr] <= i_wr_data;
      else          r_a[i_wr_addr] <= i_wr_data;
    end
  end

  // Row i / column j is delayed by i / j steps so operands meet on the diagonal.
  always_comb begin
    int k;
    k       = 0;
    o_a_row = '0;
    o_b_col = '0;
    for (int i = 0; i < DIM; i++) begin
      k = int'(i_step) - i;
      if (i_feed_valid && k >= 0 && k < DIM) begin
        o_a_row[i*DATA_WIDTH +: DATA_WIDTH] = r_a[ADDR_W'(i*DIM + k)];
        o_b_col[i*DATA_WIDTH +: DATA_WIDTH] = r_b[ADDR_W'(k*DIM + i)];
      end
    end
  end
endmodule

// File: rtl/array_ctrl.sv
// Job sequencer for a 4x4 systolic MAC array: clear, skewed feed, capture, done pulse.
//   state   | meaning
//   IDLE    | waiting for start, operand writes accepted
//   CLEAR   | one cycle holding the array accumulators cleared
//   FEED    | FEED_CYCLES steps of skewed operands with MAC enabled
//   CAPTURE | array results registered into res_data at the closing edge
//   DONE    | one-cycle done pulse, then back to IDLE
module array_ctrl #(
  parameter int DIM         = array_pkg::DIM,
  parameter int DATA_WIDTH  = array_pkg::DATA_WIDTH,
  parameter int ACC_WIDTH   = array_pkg::ACC_WIDTH,
  parameter int FEED_CYCLES = array_pkg::FEED_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic                          wr_sel,
  input  logic [3:0]                    wr_addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          arr_rst_n,
  output logic                          arr_we,
  output logic [DATA_WIDTH*DIM-1:0]     arr_a_in,
  output logic [DATA_WIDTH*DIM-1:0]     arr_b_in,
  input  logic [ACC_WIDTH*DIM*DIM-1:0]  arr_data_in,
  output logic [ACC_WIDTH*DIM*DIM-1:0]  res_data
);
  import array_pkg::*;

  state_t                         r_state;
  state_t                         w_next;
  logic [STEP_W-1:0]              r_step;
  logic [ACC_WIDTH*DIM*DIM-1:0]   r_res;
  logic                           w_feed;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_step  <= '0;
    end else begin
      r_state <= w_next;
      r_step  <= (r_state == S_FEED) ? r_step + STEP_W'(1) : '0;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_CLEAR;
      S_CLEAR:   w_next = S_FEED;
      S_FEED:    if (r_step == STEP_W'(FEED_CYCLES - 1)) w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                       r_res <= '0;
    else if (r_state == S_CAPTURE) r_res <= arr_data_in;
  end

  // Outputs are also gated by rst directly so the array is held cleared for the whole reset.
  always_comb begin
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_DONE);
    w_feed    = (r_state == S_FEED);
    arr_rst_n = (r_state != S_CLEAR);
    if (rst) begin
      busy      = 1'b0;
      done      = 1'b0;
      w_feed    = 1'b0;
      arr_rst_n = 1'b0;
    end
    arr_we = w_feed;
  end

  assign res_data = r_res;

  operand_skew #(
    .DIM        (DIM),
    .DATA_WIDTH (DATA_WIDTH),
    .STEP_W     (STEP_W),
    .ADDR_W     (ADDR_W)
  ) u_skew (
    .clk          (clk),
    .i_rst        (rst),
    .i_wr_en      (wr_en && !busy),
    .i_wr_sel     (wr_sel),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .i_step       (r_step),
    .i_feed_valid (w_feed),
    .o_a_row      (arr_a_in),
    .o_b_col      (arr_b_in)
  );
endmodule
